// File: rtl/adc128s022_scanner_pkg.sv
// Shared constants, FSM state type and channel-mask helpers for the
// ADC128S022 scanner.
//   ADC_BITS       conversion width
//   N_CH           number of ADC input channels
//   FRAME_BITS     SCLK periods per SPI frame
//   ADDR_FIRST_BIT first frame bit carrying the channel address (3 bits)
//   DATA_FIRST_BIT first frame bit carrying conversion data (12 bits)
package adc128s022_scanner_pkg;
  localparam int unsigned ADC_BITS       = 12;
  localparam int unsigned N_CH           = 8;
  localparam int unsigned FRAME_BITS     = 16;
  localparam int unsigned ADDR_FIRST_BIT = 3;
  localparam int unsigned DATA_FIRST_BIT = 5;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, FRAME_END, HOLD} adc_state_t;

  // An empty mask would leave nothing to scan, so it falls back to ch0.
  function automatic logic [7:0] eff_mask(input logic [7:0] m);
    return (m == '0) ? 8'h01 : m;
  endfunction

  // Next set mask bit strictly above cur, wrapping; returns cur when it is
  // the only set bit (the 8th step wraps back onto cur itself).
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] c;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      c = cur + 3'(i);
      if (!found && mask[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/adc128s022_scanner_if.sv
// SPI bus between the scanner (master) and the ADC128S022 (slave).
//   adc_cs_n  chip select, active low
//   adc_sclk  serial clock, idles high
//   adc_din   channel address to ADC, MSB first
//   adc_dout  conversion data from ADC
interface adc128s022_scanner_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_din;
  logic adc_dout;

  modport master (output adc_cs_n, output adc_sclk, output adc_din, input adc_dout);
  modport slave  (input adc_cs_n, input adc_sclk, input adc_din, output adc_dout);
endinterface

// File: rtl/adc128s022_scanner_spi_clk_div.sv
// SCLK timebase: one-clk tick every CLK_DIV clks.
//   clk, rst_n  system clock, async active-low reset
//   clear       synchronous clear, holds the counter at zero
//   tick        strobe, high for one clk every CLK_DIV clks
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam logic [7:0] TOP = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/adc128s022_scanner.sv
// Continuous round-robin SPI scanner for the ADC128S022.
//   clk, rst_n    system clock, async active-low reset
//   enable        1 = scan; 0 = stop after the current frame
//   spi           SPI master port (cs_n, sclk, din out; dout in)
//   samples       8 x 12-bit held codes, ch i at [12*i+11:12*i]
//   sample_valid  one-clk pulse when a samples slot is updated
//   sample_ch     channel of the slot just updated
//   busy          high while chip select is asserted
module adc128s022_scanner
  import adc128s022_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10,
  parameter logic [7:0]  CH_MASK = 8'b0000_0011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  adc128s022_scanner_if.master     spi,
  output logic [N_CH*ADC_BITS-1:0] samples,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
  output logic                     busy
);
  localparam logic [7:0] MASK_EFF = eff_mask(CH_MASK);
  localparam logic [2:0] FIRST_CH = next_ch(MASK_EFF, 3'(N_CH - 1));
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);
  localparam logic [4:0] DATA_LO  = 5'(DATA_FIRST_BIT);
  localparam logic [4:0] ADDR_B2  = 5'(ADDR_FIRST_BIT);
  localparam logic [4:0] ADDR_B1  = 5'(ADDR_FIRST_BIT + 1);
  localparam logic [4:0] ADDR_B0  = 5'(ADDR_FIRST_BIT + 2);

  adc_state_t          state, state_nxt;
  logic                tick;
  logic                cs_n_q, sclk_q, din_q;
  logic [4:0]          bit_cnt;
  logic [ADC_BITS-1:0] rx;
  logic                first_frame, hold_half, addr_bit;
  logic [2:0]          cur_ch, prev_ch;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sclk = sclk_q;
  assign spi.adc_din  = din_q;
  assign busy         = ~cs_n_q;

  always_comb begin
    addr_bit = 1'b0;
    case (bit_cnt)
      ADDR_B2: addr_bit = cur_ch[2];
      ADDR_B1: addr_bit = cur_ch[1];
      ADDR_B0: addr_bit = cur_ch[0];
      default: addr_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (enable) state_nxt = SETUP;
      SETUP:     if (tick) state_nxt = SHIFT;
      SHIFT:     if (tick && !sclk_q && bit_cnt == LAST_BIT) state_nxt = FRAME_END;
      FRAME_END: state_nxt = enable ? SHIFT : HOLD;
      HOLD:      if (tick && hold_half) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      din_q        <= 1'b0;
      bit_cnt      <= 5'd1;
      rx           <= '0;
      first_frame  <= 1'b1;
      hold_half    <= 1'b0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      samples      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: if (enable) cs_n_q <= 1'b0;
        SETUP: if (tick) begin
          first_frame <= 1'b1;
          cur_ch      <= FIRST_CH;
          bit_cnt     <= 5'd1;
        end
        SHIFT: if (tick) begin
          if (sclk_q) begin
            sclk_q <= 1'b0;
            din_q  <= addr_bit;
          end else begin
            sclk_q <= 1'b1;
            if (bit_cnt >= DATA_LO) rx <= {rx[ADC_BITS-2:0], spi.adc_dout};
            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        FRAME_END: begin
          // Data in this frame belongs to the address sent one frame earlier.
          if (!first_frame) begin
            for (int unsigned i = 0; i < N_CH; i++)
              if (prev_ch == 3'(i)) samples[i*ADC_BITS +: ADC_BITS] <= rx;
            sample_ch    <= prev_ch;
            sample_valid <= 1'b1;
          end
          prev_ch     <= cur_ch;
          cur_ch      <= next_ch(MASK_EFF, cur_ch);
          first_frame <= 1'b0;
          bit_cnt     <= 5'd1;
          hold_half   <= 1'b0;
          if (!enable) cs_n_q <= 1'b1;
        end
        HOLD: if (tick) hold_half <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc128s022_scanner.sv
// Directed bench: four scanner instances (masks 01, 05, 00, 80) each talking
// to a behavioural ADC128S022 model; expected samples queued per instance.
module tb_adc128s022_scanner;
  localparam int unsigned CLK_DIV = 10;
  localparam logic [7:0] MASKS [4] = '{8'h01, 8'h05, 8'h00, 8'h80};
  localparam int FIRST_LAT = CLK_DIV + 64 * CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en   [4];
  logic [95:0] samp [4];
  logic        sv   [4];
  logic [2:0]  sch  [4];
  logic        bsy  [4];
  logic        csn  [4];
  logic        sck  [4];
  logic [11:0] codes [4][8];
  logic [14:0] exp_q [4][$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] tb_next(input logic [7:0] m, input logic [2:0] c);
    logic [7:0] e;
    int k2;
    e = (m == 8'h00) ? 8'h01 : m;
    for (int k = 1; k <= 8; k++) begin
      k2 = (int'(c) + k) % 8;
      if (e[k2]) return 3'(k2);
    end
    return c;
  endfunction

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g
    localparam logic [7:0] M = MASKS[gi];
    adc128s022_scanner_if bus();
    logic [95:0] s_w;
    logic        v_w, b_w;
    logic [2:0]  c_w;

    adc128s022_scanner #(.CLK_DIV(CLK_DIV), .CH_MASK(M)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (en[gi]),
      .spi          (bus.master),
      .samples      (s_w),
      .sample_valid (v_w),
      .sample_ch    (c_w),
      .busy         (b_w)
    );
    assign samp[gi] = s_w;
    assign sv[gi]   = v_w;
    assign sch[gi]  = c_w;
    assign bsy[gi]  = b_w;
    assign csn[gi]  = bus.adc_cs_n;
    assign sck[gi]  = bus.adc_sclk;

    // ADC model: address decoded from DIN bits 3-5, converted next frame.
    int          mf = 0, mr = 0, rises = 0;
    logic        p_sclk = 1'b1, m_first = 1'b1;
    logic [2:0]  maddr = '0, mconv = '0, mexp = '0;
    logic [11:0] msh = '0;
    always @(bus.adc_sclk or bus.adc_cs_n) begin
      if (bus.adc_cs_n !== 1'b0) begin
        mf = 0; mr = 0; m_first = 1'b1;
      end else if (rst_n) begin
        if (p_sclk === 1'b1 && bus.adc_sclk === 1'b0) begin
          mf++;
          if (mf == 1) msh = codes[gi][mconv];
          if (m_first) begin mexp = tb_next(M, 3'd7); m_first = 1'b0; end
          bus.adc_dout = (mf >= 5) ? msh[16-mf] : 1'b0;
        end else if (p_sclk === 1'b0 && bus.adc_sclk === 1'b1) begin
          mr++;
          rises++;
          if (mr >= 3 && mr <= 5) maddr[5-mr] = bus.adc_din;
          if (mr == 16) begin
            check("din_addr", 64'(maddr), 64'(mexp));
            mconv = maddr;
            mexp  = tb_next(M, mexp);
            mr = 0; mf = 0;
          end
        end
      end
      p_sclk = bus.adc_sclk;
    end

    logic din_f = 1'b0;
    always @(negedge bus.adc_sclk) begin #1 din_f = bus.adc_din; end
    always @(posedge bus.adc_sclk) if (rst_n && bus.adc_cs_n === 1'b0) begin
      #1;
      if (rst_n) check("din_stable", 64'(bus.adc_din), 64'(din_f));
    end
    always @(bus.adc_sclk) if (rst_n === 1'b1) check("sclk_cs", 64'(bus.adc_cs_n), 0);

    always @(negedge clk) if (rst_n === 1'b1 && v_w === 1'b1) begin : mon
      logic [14:0] e;
      int c;
      if (exp_q[gi].size() == 0) check("sb_pending", 64'(exp_q[gi].size()), 1);
      else begin
        e = exp_q[gi].pop_front();
        c = int'(e[14:12]);
        check("sample_ch", 64'(c_w), 64'(e[14:12]));
        check("sample_code", 64'(s_w[c*12 +: 12]), 64'(e[11:0]));
      end
    end
  end

  task automatic push_run(input int k, input int n);
    logic [2:0] c;
    c = tb_next(MASKS[k], 3'd7);
    for (int i = 0; i < n; i++) begin
      exp_q[k].push_back({c, codes[k][c]});
      c = tb_next(MASKS[k], c);
    end
  endtask

  task automatic wait_valid(input int k, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (sv[k] !== 1'b1 && n < budget);
    check("valid_timeout", 64'(sv[k]), 1);
  endtask

  task automatic wait_cs_low(input int k);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (csn[k] !== 1'b0 && n < 50);
    check("cs_low_timeout", 64'(csn[k]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r1, r2, t0, per;
    logic prev;
    for (int k = 0; k < 4; k++) begin
      en[k] = 1'b0;
      for (int c = 0; c < 8; c++) codes[k][c] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(csn[0]), 1);
    check("rst_sclk", 64'(sck[0]), 1);
    check("rst_din", 64'(g[0].bus.adc_din), 0);
    check("rst_samples", samp[0][63:0] | 64'(samp[0][95:64]), 0);
    check("rst_valid", 64'(sv[0]), 0);
    check("rst_ch", 64'(sch[0]), 0);
    check("rst_busy", 64'(bsy[0]), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single channel, latency, SCLK period, pulses per frame
    codes[0][0] = 12'hA5C;
    codes[0][1] = 12'h0F0;
    push_run(0, 3);
    en[0] = 1'b1;
    wait_cs_low(0);
    wait_valid(0, 2000, n);
    check("first_valid_lat", 64'(n), 64'(FIRST_LAT));
    r1 = g[0].rises;
    wait_valid(0, 1000, n);
    r2 = g[0].rises;
    check("rises_per_frame", 64'(r2 - r1), 16);
    prev = sck[0]; t0 = -1; per = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (prev && !sck[0]) begin
        if (t0 < 0) t0 = k;
        else begin per = k - t0; break; end
      end
      prev = sck[0];
    end
    check("sclk_period", 64'(per), 64'(2 * CLK_DIV));
    en[0] = 1'b0;
    wait_valid(0, 1000, n);
    repeat (30) @(negedge clk);
    check("t1_slot0", 64'(samp[0][11:0]), 64'h A5C);

    // 2+3: two channels, then enable dropped near bit 7
    codes[1][0] = 12'h123;
    codes[1][1] = 12'h777;
    codes[1][2] = 12'hFFF;
    push_run(1, 5);
    en[1] = 1'b1;
    wait_cs_low(1);
    for (int i = 0; i < 4; i++) wait_valid(1, 2000, n);
    repeat (130) @(negedge clk);
    check("busy_in_frame", 64'(bsy[1]), 1);
    en[1] = 1'b0;
    wait_valid(1, 1000, n);
    repeat (19) @(negedge clk);
    check("hold_cs_n", 64'(csn[1]), 1);
    check("hold_busy", 64'(bsy[1]), 0);
    repeat (40) @(negedge clk);
    check("idle_cs_n", 64'(csn[1]), 1);
    check("t2_slot0", 64'(samp[1][11:0]), 64'h123);
    check("t2_slot1", 64'(samp[1][23:12]), 0);
    check("t2_slot2", 64'(samp[1][35:24]), 64'hFFF);

    // 4: reset mid-SHIFT, then first frame is discarded again
    push_run(0, 1);
    en[0] = 1'b1;
    wait_cs_low(0);
    wait_valid(0, 2000, n);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    en[0] = 1'b0;
    #1;
    check("mid_rst_cs_n", 64'(csn[0]), 1);
    check("mid_rst_sclk", 64'(sck[0]), 1);
    check("mid_rst_samples", samp[0][63:0] | 64'(samp[0][95:64]), 0);
    check("mid_rst_busy", 64'(bsy[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    codes[0][0] = 12'h3C3;
    push_run(0, 2);
    en[0] = 1'b1;
    wait_cs_low(0);
    wait_valid(0, 2000, n);
    check("post_rst_lat", 64'(n), 64'(FIRST_LAT));
    en[0] = 1'b0;
    wait_valid(0, 1000, n);
    repeat (30) @(negedge clk);

    // short enable pulse between clock edges is not sampled
    @(negedge clk);
    en[2] = 1'b1;
    #2 en[2] = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_cs_n", 64'(csn[2]), 1);

    // 5: empty mask scans ch0; mask 80 scans ch7
    codes[2][0] = 12'h7E1;
    codes[2][1] = 12'h111;
    codes[3][7] = 12'h001;
    codes[3][0] = 12'hABC;
    push_run(2, 3);
    push_run(3, 3);
    en[2] = 1'b1;
    en[3] = 1'b1;
    wait_cs_low(2);
    wait_valid(2, 2000, n);
    wait_valid(2, 1000, n);
    en[2] = 1'b0;
    en[3] = 1'b0;
    wait_valid(2, 1000, n);
    repeat (50) @(negedge clk);
    check("t5_m00_slot0", 64'(samp[2][11:0]), 64'h7E1);
    check("t5_m00_slot1", 64'(samp[2][23:12]), 0);
    check("t5_m80_slot7", 64'(samp[3][95:84]), 64'h001);
    check("t5_m80_low", samp[3][63:0] | 64'(samp[3][83:64]), 0);

    for (int k = 0; k < 4; k++) check("sb_drained", 64'(exp_q[k].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
